ili9341_init_seq: RTL and testbench



---
 rtl/ili9341_init_seq.sv | 171 +++++++++++++++++
 tb/tb_ili9341_init_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ili9341_init_seq.sv
// ILI9341 power-up sequencer: panel reset handshake, then command ROM walk.
// Optional watchdog on the reset and byte handshakes: define ILI_INIT_WDOG_EN.
module ili9341_init_seq #(
    parameter int DELAY_UNIT_CYCLES = 100_000,
    parameter int ROM_DEPTH = 16
`ifdef ILI_INIT_WDOG_EN
    ,
    parameter int WDOG_CYCLES = 40_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    output logic       o_reset_ena,
    output logic       o_reset_val,
    input  logic       i_reset_sent,
    output logic [7:0] o_byte,
    output logic       o_dc,
    output logic       o_byte_valid,
    input  logic       i_byte_ready,
    output logic       o_busy,
    output logic       o_init_done,
    output logic       o_error
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RST_REQ  = 3'd1;
    localparam logic [2:0] S_RST_WAIT = 3'd2;
    localparam logic [2:0] S_FETCH    = 3'd3;
    localparam logic [2:0] S_SEND     = 3'd4;
    localparam logic [2:0] S_DELAY    = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam logic [1:0] T_CMD = 2'b00;
    localparam logic [1:0] T_DAT = 2'b01;
    localparam logic [1:0] T_DLY = 2'b10;
    localparam logic [1:0] T_END = 2'b11;

    localparam int PW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int CW = (DELAY_UNIT_CYCLES > 1) ? $clog2(DELAY_UNIT_CYCLES) : 1;
    localparam logic [PW-1:0] PTR_MAX  = PW'(ROM_DEPTH - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(DELAY_UNIT_CYCLES - 1);

    logic [2:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_inc;
    logic [CW-1:0] cyc;
    logic [7:0]    units;
    logic [9:0]    entry;
    logic          last_cyc;
    logic          start_ok;
    logic          wd_trip;

    function automatic logic [9:0] rom_at(input logic [PW-1:0] a);
        case (int'(a))
            0:       return {T_CMD, 8'h01};
            1:       return {T_DLY, 8'd5};
            2:       return {T_CMD, 8'h11};
            3:       return {T_DLY, 8'd120};
            4:       return {T_CMD, 8'h3A};
            5:       return {T_DAT, 8'h55};
            6:       return {T_CMD, 8'h36};
            7:       return {T_DAT, 8'h48};
            8:       return {T_CMD, 8'h29};
            9:       return {T_DLY, 8'd1};
            default: return {T_END, 8'h00};
        endcase
    endfunction

    assign entry    = rom_at(ptr);
    assign ptr_inc  = (ptr == PTR_MAX) ? ptr : ptr + 1'b1;
    assign last_cyc = (cyc == CYC_LAST);
    assign start_ok = i_start && (state == S_IDLE || state == S_DONE);

    assign o_reset_ena  = (state == S_RST_REQ);
    assign o_reset_val  = !(state == S_RST_REQ || state == S_RST_WAIT);
    assign o_byte_valid = (state == S_SEND);
    assign o_busy       = !(state == S_IDLE || state == S_DONE);
    assign o_init_done  = (state == S_DONE);

`ifdef ILI_INIT_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0] wd;
    logic          watched;
    logic          err;

    // Every watched state is entered from an unwatched one, so clearing
    // outside them restarts the count on each entry.
    assign watched = (state == S_RST_WAIT) || (state == S_SEND);
    assign wd_trip = watched && (wd == WD_LAST);
    assign o_error = err;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd  <= '0;
            err <= 1'b0;
        end else begin
            if (!watched || wd_trip) wd <= '0;
            else wd <= wd + 1'b1;
            if (wd_trip) err <= 1'b1;
            else if (start_ok) err <= 1'b0;
        end
    end
`else
    assign wd_trip = 1'b0;
    assign o_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ptr    <= '0;
            cyc    <= '0;
            units  <= '0;
            o_byte <= 8'h00;
            o_dc   <= 1'b0;
        end else if (wd_trip) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state <= S_RST_REQ;
                        ptr   <= '0;
                    end
                end
                S_RST_REQ: state <= S_RST_WAIT;
                S_RST_WAIT: begin
                    if (i_reset_sent) state <= S_FETCH;
                end
                S_FETCH: begin
                    unique case (entry[9:8])
                        T_CMD, T_DAT: begin
                            o_byte <= entry[7:0];
                            o_dc   <= entry[8];
                            state  <= S_SEND;
                        end
                        T_DLY: begin
                            units <= entry[7:0];
                            cyc   <= '0;
                            state <= S_DELAY;
                        end
                        T_END: state <= S_DONE;
                    endcase
                end
                S_SEND: begin
                    if (i_byte_ready) begin
                        ptr   <= ptr_inc;
                        state <= S_FETCH;
                    end
                end
                S_DELAY: begin
                    // A zero-length delay still occupies this state for one cycle.
                    if (units == 8'd0 || (units == 8'd1 && last_cyc)) begin
                        ptr   <= ptr_inc;
                        state <= S_FETCH;
                    end else if (last_cyc) begin
                        cyc   <= '0;
                        units <= units - 8'd1;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ili9341_init_seq.sv
// Scoreboard bench for ili9341_init_seq with a 3-cycle reset-stage model.
// Define ILI_INIT_WDOG_EN to also exercise the watchdog path.
module tb_ili9341_init_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_reset_sent = 1'b0;
    logic       i_byte_ready = 1'b1;
    logic       o_reset_ena;
    logic       o_reset_val;
    logic [7:0] o_byte;
    logic       o_dc;
    logic       o_byte_valid;
    logic       o_busy;
    logic       o_init_done;
    logic       o_error;

    always #5 clk = ~clk;

    ili9341_init_seq #(
        .DELAY_UNIT_CYCLES(10),
        .ROM_DEPTH(16)
`ifdef ILI_INIT_WDOG_EN
        ,
        .WDOG_CYCLES(100)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_start(i_start),
        .o_reset_ena(o_reset_ena),
        .o_reset_val(o_reset_val),
        .i_reset_sent(i_reset_sent),
        .o_byte(o_byte),
        .o_dc(o_dc),
        .o_byte_valid(o_byte_valid),
        .i_byte_ready(i_byte_ready),
        .o_busy(o_busy),
        .o_init_done(o_init_done),
        .o_error(o_error)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_xfer = 0;
    int n_55 = 0;
    int n_rena = 0;
    int t_xfer[256];
    int t_done = 0;
    bit rs_en = 1'b1;
    logic [8:0] exp_q[$];
    logic [8:0] e;

    // {ena,val,byte,dc,valid,busy,done,error} after reset
    localparam logic [14:0] RST_VEC = {1'b0, 1'b1, 8'h00, 5'b00000};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic logic [14:0] out_vec();
        return {o_reset_ena, o_reset_val, o_byte, o_dc, o_byte_valid,
                o_busy, o_init_done, o_error};
    endfunction

    task automatic push_seq();
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h011);
        exp_q.push_back(9'h03A);
        exp_q.push_back(9'h155);
        exp_q.push_back(9'h036);
        exp_q.push_back(9'h148);
        exp_q.push_back(9'h029);
    endtask

    task automatic clear_counts();
        n_xfer = 0;
        n_55 = 0;
        n_rena = 0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int lim, input string name);
        int k = 0;
        while (!o_init_done && k < lim) begin
            @(negedge clk);
            k++;
        end
        t_done = cyc;
        check(name, o_init_done, 1);
    endtask

    task automatic wait_byte(input logic [7:0] b, input int lim,
                             input string name);
        int k = 0;
        while (!(o_byte_valid && o_byte == b) && k < lim) begin
            @(negedge clk);
            k++;
        end
        check(name, {o_byte_valid, o_byte}, {1'b1, b});
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reset stage model: done pulse 3 cycles after the request.
    initial forever begin
        @(negedge clk);
        if (o_reset_ena && rs_en) begin
            repeat (3) @(negedge clk);
            i_reset_sent = 1'b1;
            @(negedge clk);
            i_reset_sent = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every accepted byte.
    initial forever begin
        @(negedge clk);
        #1;
        if (o_reset_ena) n_rena++;
        if (o_byte_valid && i_byte_ready) begin
            n_xfer++;
            t_xfer[o_byte] = cyc;
            if (o_byte == 8'h55) n_55++;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_extra: got %0d/%h want none", o_dc, o_byte);
            end else begin
                e = exp_q.pop_front();
                check("sb_byte", {23'd0, o_dc, o_byte}, {23'd0, e});
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), RST_VEC);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", out_vec(), RST_VEC);

        // Run 1: nominal sequence
        clear_counts();
        push_seq();
        pulse_start();
        check("start_latency", {o_reset_ena, o_reset_val, o_busy}, 3'b101);
        wait_done(3000, "run1_done");
        check("run1_xfers", n_xfer, 7);
        check("run1_q_empty", exp_q.size(), 0);
        check("run1_rena", n_rena, 1);
        check("gap_01_11", (t_xfer[8'h11] - t_xfer[8'h01]) >= 50, 1);
        check("gap_11_3a", (t_xfer[8'h3A] - t_xfer[8'h11]) >= 1200, 1);
        check("done_latency", t_done - t_xfer[8'h29], 13);
        check("done_idle_out", {o_busy, o_reset_val}, 2'b01);

        // Run 2: restart from DONE, ready stall, start while busy
        clear_counts();
        push_seq();
        pulse_start();
        check("restart_clr", {o_init_done, o_reset_ena}, 2'b01);
        wait_byte(8'h55, 2000, "find_55");
        i_byte_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("stall_hold", {o_byte_valid, o_dc, o_byte}, {2'b11, 8'h55});
            @(negedge clk);
        end
        i_byte_ready = 1'b1;
        wait_byte(8'h36, 200, "find_36");
        pulse_start();
        check("busy_start", o_busy, 1);
        wait_done(3000, "run2_done");
        check("run2_xfers", n_xfer, 7);
        check("run2_55_once", n_55, 1);
        check("run2_rena", n_rena, 1);
        check("run2_q_empty", exp_q.size(), 0);

        // Run 3: rst during the 120-unit delay
        clear_counts();
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h011);
        pulse_start();
        for (int k = 0; k < 500 && n_xfer < 2; k++) @(negedge clk);
        check("run3_two", n_xfer, 2);
        repeat (100) @(negedge clk);
        check("in_delay", {o_busy, o_byte_valid}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", out_vec(), RST_VEC);
        rst = 1'b0;
        repeat (1500) @(negedge clk);
        check("abort_quiet", {n_xfer[7:0], n_rena[7:0]}, {8'd2, 8'd1});
        check("abort_idle", {o_busy, o_init_done}, 2'b00);

        // Run 4: recovery after abort
        clear_counts();
        push_seq();
        pulse_start();
        wait_done(3000, "run4_done");
        check("run4_xfers", n_xfer, 7);

`ifdef ILI_INIT_WDOG_EN
        rs_en = 1'b0;
        pulse_start();
        check("wd_req", o_reset_ena, 1);
        repeat (100) @(negedge clk);
        check("wd_pre", {o_error, o_reset_val, o_busy}, 3'b001);
        @(negedge clk);
        check("wd_trip", {o_error, o_busy, o_reset_val, o_init_done},
              4'b1010);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
